serial_code_conv: RTL and testbench

Parametrised serial Gray/binary code converter: a parallel word is loaded, shifted out MSB-first through a one-bit conversion cell, and reassembled into a parallel result. It generalises the fixed 5-bit serial Gray-to-binary datapath to any width of 2 or more. It adds a binary-to-Gray mode and a load/busy/valid handshake. It sits between parallel producers and consumers, where a bit-serial conversion core saves area over a full-width XOR tree.

---
 rtl/serial_conv_pkg.sv | 11 +
 rtl/code_conv_bit.sv | 36 +++
 rtl/serial_code_conv.sv | 130 +++++++++++++
 tb/tb_serial_code_conv.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_conv_pkg.sv
// Shared constants for the serial Gray/binary converter: conversion modes and FSM state encoding.
package serial_conv_pkg;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  localparam int STATE_W = 1;
  localparam logic [STATE_W-1:0] ST_IDLE  = 1'b0;
  localparam logic [STATE_W-1:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/code_conv_bit.sv
// One-bit Gray/binary conversion cell: holds the running accumulator and converts one serial bit per enabled cycle.
module code_conv_bit
  import serial_conv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic mode,
  input  logic s,
  output logic r
);

  logic acc_q, acc_d;

  assign r = acc_q ^ s;

  // Gray decode keeps the running XOR; Gray encode only needs the previous input bit.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = 1'b0;
    end else if (en) begin
      acc_d = (mode == MODE_B2G) ? s : r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/serial_code_conv.sv
// Serial Gray/binary converter: loads a word, streams it MSB-first through code_conv_bit and reassembles it.
// Optional parity output enabled by defining SERIAL_CONV_PARITY_EN.
module serial_code_conv
  import serial_conv_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic [WIDTH-1:0] dout,
  output logic             valid
`ifdef SERIAL_CONV_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-2:0]   collect_q, collect_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               valid_q, valid_d;
`ifdef SERIAL_CONV_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic             cellClr;
  logic             cellEn;
  logic             cellOut;
  logic [WIDTH-1:0] assembled;

  code_conv_bit u_cell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cellClr),
    .en    (cellEn),
    .mode  (mode_q),
    .s     (shift_q[WIDTH-1]),
    .r     (cellOut)
  );

  // The word being built, including the bit the cell produces this cycle.
  assign assembled = {collect_q, cellOut};

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    collect_d = collect_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    cellClr   = 1'b0;
    cellEn    = 1'b0;
`ifdef SERIAL_CONV_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          shift_d   = din;
          mode_d    = mode;
          cnt_d     = '0;
          collect_d = '0;
          cellClr   = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        cellEn    = 1'b1;
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        collect_d = assembled[WIDTH-2:0];
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          dout_d  = assembled;
          valid_d = 1'b1;
`ifdef SERIAL_CONV_PARITY_EN
          parity_d = ^assembled;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      collect_q <= '0;
      cnt_q     <= '0;
      mode_q    <= MODE_G2B;
      dout_q    <= '0;
      valid_q   <= 1'b0;
`ifdef SERIAL_CONV_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      collect_q <= collect_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
`ifdef SERIAL_CONV_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign busy  = (state_q == ST_SHIFT);
  assign dout  = dout_q;
  assign valid = valid_q;
`ifdef SERIAL_CONV_PARITY_EN
  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_serial_code_conv.sv
// Bench for serial_code_conv at WIDTH 5 and 8 against a word-level Gray/binary model with latency tracking.
// Parity checks are included when SERIAL_CONV_PARITY_EN is defined.
module tb_serial_code_conv;

  logic clk = 1'b0;
  logic rst_n;

  int testsRun = 0;
  int testsFailed = 0;

  int          wid [2] = '{5, 8};
  logic        loadIn [2];
  logic        modeIn [2];
  logic [31:0] dinIn [2];

  logic        busy5, valid5, busy8, valid8;
  logic [4:0]  dout5;
  logic [7:0]  dout8;
`ifdef SERIAL_CONV_PARITY_EN
  logic        par5, par8;
`endif

  always #5 clk = ~clk;

  serial_code_conv #(.WIDTH(5)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (loadIn[0]),
    .mode  (modeIn[0]),
    .din   (dinIn[0][4:0]),
    .busy  (busy5),
    .dout  (dout5),
    .valid (valid5)
`ifdef SERIAL_CONV_PARITY_EN
    ,
    .parity(par5)
`endif
  );

  serial_code_conv #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (loadIn[1]),
    .mode  (modeIn[1]),
    .din   (dinIn[1][7:0]),
    .busy  (busy8),
    .dout  (dout8),
    .valid (valid8)
`ifdef SERIAL_CONV_PARITY_EN
    ,
    .parity(par8)
`endif
  );

  // Reference conversion straight from the code definitions.
  function automatic logic [31:0] refConv(input logic [31:0] val, input logic md, input int w);
    logic [31:0] v;
    logic [31:0] res;
    logic        acc;
    v   = val & ((32'd1 << w) - 32'd1);
    res = '0;
    if (md) begin
      res = v ^ (v >> 1);
    end else begin
      acc = 1'b0;
      for (int i = w - 1; i >= 0; i--) begin
        acc    = acc ^ v[i];
        res[i] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic busyOf(input int k);
    return (k == 0) ? busy5 : busy8;
  endfunction

  function automatic logic validOf(input int k);
    return (k == 0) ? valid5 : valid8;
  endfunction

  function automatic logic [31:0] doutOf(input int k);
    return (k == 0) ? {27'd0, dout5} : {24'd0, dout8};
  endfunction

`ifdef SERIAL_CONV_PARITY_EN
  function automatic logic parityOf(input int k);
    return (k == 0) ? par5 : par8;
  endfunction
`endif

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Word-level model: accepted load, completion WIDTH edges later.
  logic        mBusy [2];
  int          mCnt [2];
  logic [31:0] mRes [2];
  logic [31:0] mDout [2];
  logic        mValid [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mBusy[k]  <= 1'b0;
        mCnt[k]   <= 0;
        mRes[k]   <= '0;
        mDout[k]  <= '0;
        mValid[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        mValid[k] <= 1'b0;
        if (mBusy[k]) begin
          mCnt[k] <= mCnt[k] + 1;
          if (mCnt[k] + 1 == wid[k]) begin
            mBusy[k]  <= 1'b0;
            mValid[k] <= 1'b1;
            mDout[k]  <= mRes[k];
          end
        end else if (loadIn[k]) begin
          mBusy[k] <= 1'b1;
          mCnt[k]  <= 0;
          mRes[k]  <= refConv(dinIn[k], modeIn[k], wid[k]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("dut%0d busy", wid[k]), {31'd0, busyOf(k)}, {31'd0, mBusy[k]});
        checkOutput($sformatf("dut%0d valid", wid[k]), {31'd0, validOf(k)}, {31'd0, mValid[k]});
        checkOutput($sformatf("dut%0d dout", wid[k]), doutOf(k), mDout[k]);
`ifdef SERIAL_CONV_PARITY_EN
        checkOutput($sformatf("dut%0d parity", wid[k]), {31'd0, parityOf(k)}, {31'd0, ^mDout[k]});
`endif
      end
    end
  end

  // One-cycle load pulse; returns at the negedge after the load edge.
  task automatic applyStimulus(input int k, input logic [31:0] d, input logic md);
    loadIn[k] = 1'b1;
    dinIn[k]  = d;
    modeIn[k] = md;
    @(negedge clk);
    loadIn[k] = 1'b0;
  endtask

  task automatic waitValid(input int k, output int cycles, output int busyCycles);
    cycles = 0;
    busyCycles = 0;
    while (validOf(k) !== 1'b1 && cycles < 40) begin
      if (busyOf(k) === 1'b1) busyCycles++;
      @(negedge clk);
      cycles++;
    end
    if (validOf(k) !== 1'b1) checkOutput($sformatf("dut%0d valid timeout", wid[k]), 32'd0, 32'd1);
  endtask

  int          cyc, busyCyc;
  logic [31:0] b2gRes [256];

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      loadIn[k] = 1'b0;
      modeIn[k] = 1'b0;
      dinIn[k]  = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    checkOutput("ref g2b 11010", refConv(32'b11010, 1'b0, 5), 32'b10011);
    checkOutput("ref b2g 10110", refConv(32'b10110, 1'b1, 5), 32'b11101);
    checkOutput("ref g2b 00001", refConv(32'b00001, 1'b0, 5), 32'b00001);
    checkOutput("reset busy", {31'd0, busy5}, 32'd0);
    checkOutput("reset dout", {27'd0, dout5}, 32'd0);

    applyStimulus(0, 32'b11010, 1'b0);
    waitValid(0, cyc, busyCyc);
    checkOutput("g2b latency", cyc, 32'd5);
    checkOutput("g2b busy cycles", busyCyc, 32'd5);
    checkOutput("g2b dout", {27'd0, dout5}, 32'b10011);
    @(negedge clk);
    checkOutput("valid single pulse", {31'd0, valid5}, 32'd0);

    applyStimulus(0, 32'b10110, 1'b1);
    waitValid(0, cyc, busyCyc);
    checkOutput("b2g dout", {27'd0, dout5}, 32'b11101);
`ifdef SERIAL_CONV_PARITY_EN
    checkOutput("b2g parity", {31'd0, par5}, 32'd0);
`endif
    @(negedge clk);

    applyStimulus(0, 32'b11010, 1'b0);
    waitValid(0, cyc, busyCyc);
`ifdef SERIAL_CONV_PARITY_EN
    checkOutput("b2b parity first", {31'd0, par5}, 32'd1);
`endif
    applyStimulus(0, 32'b00001, 1'b0);
    waitValid(0, cyc, busyCyc);
    checkOutput("b2b spacing", cyc + 1, 32'd6);
    checkOutput("b2b dout second", {27'd0, dout5}, 32'b00001);
`ifdef SERIAL_CONV_PARITY_EN
    checkOutput("b2b parity second", {31'd0, par5}, 32'd1);
`endif
    @(negedge clk);

    applyStimulus(0, 32'b11010, 1'b0);
    @(negedge clk);
    applyStimulus(0, 32'b00111, 1'b1);
    waitValid(0, cyc, busyCyc);
    checkOutput("ignored load dout", {27'd0, dout5}, 32'b10011);
    @(negedge clk);
    checkOutput("ignored load not queued", {31'd0, busy5}, 32'd0);

    applyStimulus(0, 32'b10110, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", {31'd0, busy5}, 32'd0);
    checkOutput("async reset valid", {31'd0, valid5}, 32'd0);
    checkOutput("async reset dout", {27'd0, dout5}, 32'd0);
`ifdef SERIAL_CONV_PARITY_EN
    checkOutput("async reset parity", {31'd0, par5}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checkOutput("no valid after reset", {31'd0, valid5}, 32'd0);
    end
    applyStimulus(0, 32'b10110, 1'b1);
    waitValid(0, cyc, busyCyc);
    checkOutput("post reset dout", {27'd0, dout5}, 32'b11101);
    @(negedge clk);

    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 256; v++) begin
        applyStimulus(1, 32'(v), m[0]);
        waitValid(1, cyc, busyCyc);
        checkOutput($sformatf("w8 mode%0d in %0d", m, v), {24'd0, dout8}, refConv(32'(v), m[0], 8));
        if (m == 1) b2gRes[v] = {24'd0, dout8};
        @(negedge clk);
      end
    end
    for (int v = 0; v < 256; v++) begin
      applyStimulus(1, b2gRes[v], 1'b0);
      waitValid(1, cyc, busyCyc);
      checkOutput($sformatf("w8 round trip %0d", v), {24'd0, dout8}, 32'(v));
      @(negedge clk);
    end

    repeat (1500) begin
      for (int k = 0; k < 2; k++) begin
        loadIn[k] = ($urandom_range(0, 2) == 0);
        modeIn[k] = 1'($urandom_range(0, 1));
        dinIn[k]  = $urandom;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) loadIn[k] = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
